line_engine: RTL and testbench

- Hardware Bresenham line rasteriser. It sits directly downstream of the CPU's graphics line ports.
- It consumes line_color, line_point, the x0/y0/x1/y1 valid strobes and line_trigger, and returns line_ready.
- It emits one pixel per cycle, (x, y, 24-bit colour), over a valid/ready handshake to the frame-buffer pixel writer.
- Endpoint and colour registers are staged, so the CPU can preload the next line while the current one draws.

---
 rtl/line_engine.sv | 209 ++++++++++++++++++++
 tb/tb_line_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_engine.sv
// Bresenham line rasteriser: staged endpoints/colour, one pixel per cycle over valid/ready.
// Optional screen clipping is enabled by defining LINE_CLIP_EN.
module line_engine #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_color,
    input  logic               line_color_valid,
    input  logic [COORD_W-1:0] line_point,
    input  logic               line_x0_valid,
    input  logic               line_y0_valid,
    input  logic               line_x1_valid,
    input  logic               line_y1_valid,
    input  logic               line_trigger,
    output logic               line_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [23:0]        px_color,
    output logic               px_valid,
    input  logic               px_ready
);

    localparam int ERR_W = COORD_W + 2;
`ifdef LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [31:0] SCREEN_W_U = SCREEN_W;
    localparam logic [31:0] SCREEN_H_U = SCREEN_H;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t state_reg, state_next;

    // Point index order: 0=x0, 1=y0, 2=x1, 3=y1
    logic [3:0]         pt_strobe;
    logic [COORD_W-1:0] stage_pt_reg  [4];
    logic [COORD_W-1:0] stage_pt_next [4];
    logic [COORD_W-1:0] work_pt_reg   [4];
    logic [23:0]        stage_color_reg;
    logic [23:0]        stage_color_next;
    logic [23:0]        work_color_reg;
    logic               color_hi_unused;

    logic               trigger_accept;
    logic               step_en;
    logic               clipped;

    // Iterator state, all in the rotated (major = x) frame
    logic                    steep_reg;
    logic                    ystep_neg_reg;
    logic [COORD_W-1:0]      x_reg;
    logic [COORD_W-1:0]      y_reg;
    logic [COORD_W-1:0]      x_end_reg;
    logic [COORD_W-1:0]      dx_reg;
    logic [COORD_W-1:0]      dy_reg;
    logic signed [ERR_W-1:0] err_reg;

    logic [COORD_W-1:0]      adx_c, ady_c;
    logic                    steep_c, swap_c;
    logic [COORD_W-1:0]      sx0_c, sy0_c, sx1_c, sy1_c;
    logic [COORD_W-1:0]      ox0_c, oy0_c, ox1_c, oy1_c;
    logic [COORD_W-1:0]      dx_c, dy_c;

    logic signed [ERR_W-1:0] err_dec;
    logic signed [ERR_W-1:0] err_step;
    logic [COORD_W-1:0]      y_step;
    logic [COORD_W-1:0]      screen_x, screen_y;

    assign pt_strobe       = {line_y1_valid, line_x1_valid, line_y0_valid, line_x0_valid};
    assign color_hi_unused = ^line_color[31:24];

    // Write-through: a strobe in the trigger cycle is seen by that trigger
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stage
            assign stage_pt_next[gi] = pt_strobe[gi] ? line_point : stage_pt_reg[gi];
        end
    endgenerate

    assign stage_color_next = line_color_valid ? line_color[23:0] : stage_color_reg;

    always_comb begin
        adx_c   = (work_pt_reg[2] >= work_pt_reg[0]) ? (work_pt_reg[2] - work_pt_reg[0])
                                                     : (work_pt_reg[0] - work_pt_reg[2]);
        ady_c   = (work_pt_reg[3] >= work_pt_reg[1]) ? (work_pt_reg[3] - work_pt_reg[1])
                                                     : (work_pt_reg[1] - work_pt_reg[3]);
        steep_c = ady_c > adx_c;
        sx0_c   = steep_c ? work_pt_reg[1] : work_pt_reg[0];
        sy0_c   = steep_c ? work_pt_reg[0] : work_pt_reg[1];
        sx1_c   = steep_c ? work_pt_reg[3] : work_pt_reg[2];
        sy1_c   = steep_c ? work_pt_reg[2] : work_pt_reg[3];
        swap_c  = sx0_c > sx1_c;
        ox0_c   = swap_c ? sx1_c : sx0_c;
        oy0_c   = swap_c ? sy1_c : sy0_c;
        ox1_c   = swap_c ? sx0_c : sx1_c;
        oy1_c   = swap_c ? sy0_c : sy1_c;
        dx_c    = ox1_c - ox0_c;
        dy_c    = (oy1_c >= oy0_c) ? (oy1_c - oy0_c) : (oy0_c - oy1_c);
    end

    always_comb begin
        err_dec  = err_reg - $signed({2'b00, dy_reg});
        err_step = err_dec;
        y_step   = y_reg;
        if (err_dec < 0) begin
            err_step = err_dec + $signed({2'b00, dx_reg});
            y_step   = ystep_neg_reg ? (y_reg - COORD_W'(1)) : (y_reg + COORD_W'(1));
        end
    end

    assign screen_x = steep_reg ? y_reg : x_reg;
    assign screen_y = steep_reg ? x_reg : y_reg;
    assign clipped  = CLIP_EN && ((32'(screen_x) >= SCREEN_W_U) || (32'(screen_y) >= SCREEN_H_U));

    assign px_x     = screen_x;
    assign px_y     = screen_y;
    assign px_color = work_color_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        trigger_accept = 1'b0;
        step_en        = 1'b0;
        line_ready     = 1'b0;
        px_valid       = 1'b0;
        case (state_reg)
            IDLE: begin
                line_ready = 1'b1;
                if (line_trigger) begin
                    trigger_accept = 1'b1;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                state_next = DRAW;
            end
            DRAW: begin
                px_valid = !clipped;
                // Clipped pixels are skipped without waiting on the sink
                if (clipped || px_ready) begin
                    if (x_reg == x_end_reg) begin
                        state_next = IDLE;
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                stage_pt_reg[i] <= '0;
                work_pt_reg[i]  <= '0;
            end
            stage_color_reg <= '0;
            work_color_reg  <= '0;
            steep_reg       <= 1'b0;
            ystep_neg_reg   <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            x_end_reg       <= '0;
            dx_reg          <= '0;
            dy_reg          <= '0;
            err_reg         <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                stage_pt_reg[i] <= stage_pt_next[i];
                if (trigger_accept) begin
                    work_pt_reg[i] <= stage_pt_next[i];
                end
            end
            stage_color_reg <= stage_color_next;
            if (trigger_accept) begin
                work_color_reg <= stage_color_next;
            end
            if (state_reg == SETUP) begin
                steep_reg     <= steep_c;
                ystep_neg_reg <= !(oy0_c < oy1_c);
                x_reg         <= ox0_c;
                y_reg         <= oy0_c;
                x_end_reg     <= ox1_c;
                dx_reg        <= dx_c;
                dy_reg        <= dy_c;
                err_reg       <= $signed({2'b00, dx_c >> 1});
            end else if (step_en) begin
                x_reg   <= x_reg + COORD_W'(1);
                y_reg   <= y_step;
                err_reg <= err_step;
            end
        end
    end

endmodule

// File: tb/tb_line_engine.sv
// Randomised bench for line_engine: closed-form line model, per-cycle compare, directed literal checks.
module tb_line_engine;

    localparam int CW = 10;
`ifdef LINE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   line_color = '0;
    logic          line_color_valid = 1'b0;
    logic [CW-1:0] line_point = '0;
    logic          line_x0_valid = 1'b0;
    logic          line_y0_valid = 1'b0;
    logic          line_x1_valid = 1'b0;
    logic          line_y1_valid = 1'b0;
    logic          line_trigger = 1'b0;
    logic          line_ready;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic [23:0]   px_color;
    logic          px_valid;
    logic          px_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int xfers = 0;

    line_engine #(.COORD_W(CW), .SCREEN_W(800), .SCREEN_H(600)) dut (
        .clk(clk), .rst(rst),
        .line_color(line_color), .line_color_valid(line_color_valid),
        .line_point(line_point),
        .line_x0_valid(line_x0_valid), .line_y0_valid(line_y0_valid),
        .line_x1_valid(line_x1_valid), .line_y1_valid(line_y1_valid),
        .line_trigger(line_trigger), .line_ready(line_ready),
        .px_x(px_x), .px_y(px_y), .px_color(px_color),
        .px_valid(px_valid), .px_ready(px_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Model: pixel k along the major axis has minor offset ceil((k*dy - dx/2)/dx)
    pix_t line_q[$];
    function automatic void build_line(int ax0, int ay0, int ax1, int ay1, int col);
        int   steep, mj0, mn0, mj1, mn1, tmp, dx, dy, h, m, dir;
        pix_t p;
        line_q.delete();
        steep = (iabs(ay1 - ay0) > iabs(ax1 - ax0)) ? 1 : 0;
        mj0 = steep ? ay0 : ax0;  mn0 = steep ? ax0 : ay0;
        mj1 = steep ? ay1 : ax1;  mn1 = steep ? ax1 : ay1;
        if (mj0 > mj1) begin
            tmp = mj0; mj0 = mj1; mj1 = tmp;
            tmp = mn0; mn0 = mn1; mn1 = tmp;
        end
        dx  = mj1 - mj0;
        dy  = iabs(mn1 - mn0);
        h   = dx / 2;
        dir = (mn0 < mn1) ? 1 : -1;
        for (int k = 0; k <= dx; k++) begin
            m   = (dx == 0) ? 0 : (k * dy - h + dx - 1) / dx;
            p.x = steep ? (mn0 + dir * m) : (mj0 + k);
            p.y = steep ? (mj0 + k) : (mn0 + dir * m);
            p.c = col;
            line_q.push_back(p);
        end
    endfunction

    function automatic bit is_clip(pix_t p);
        return CLIP && ((p.x >= 800) || (p.y >= 600));
    endfunction

    task automatic pin(string nm, int n, int ex[8], int ey[8]);
        check({nm, "_len"}, line_q.size(), n);
        for (int k = 0; k < n && k < line_q.size(); k++) begin
            check({nm, "_x"}, line_q[k].x, ex[k]);
            check({nm, "_y"}, line_q[k].y, ey[k]);
        end
    endtask

    // Cycle-level reference and compare process
    pix_t exp_q[$];
    int   m_phase = 0;
    bit   started = 1'b0;
    int   stg[4];
    int   stg_col = 0;
    bit   prev_stall = 1'b0;
    logic [CW-1:0] prev_x, prev_y;
    logic [23:0]   prev_c;

    always @(negedge clk) begin
        bit have, clp, ev;
        int nst[4];
        int ncol;
        have = 1'b0; clp = 1'b0;
        if (m_phase == 2 && exp_q.size() > 0) begin
            have = 1'b1;
            clp  = is_clip(exp_q[0]);
        end
        ev = have && !clp;
        if (started && rst) begin
            check("line_ready", 32'(line_ready), 32'(m_phase == 0));
            check("px_valid", 32'(px_valid), 32'(ev));
            if (ev && px_valid) begin
                check("px_x", 32'(px_x), exp_q[0].x);
                check("px_y", 32'(px_y), exp_q[0].y);
                check("px_color", 32'(px_color), exp_q[0].c);
            end
            if (prev_stall) begin
                check("stall_x", 32'(px_x), 32'(prev_x));
                check("stall_y", 32'(px_y), 32'(prev_y));
                check("stall_c", 32'(px_color), 32'(prev_c));
            end
            if (px_valid && px_ready) xfers++;
        end
        if (!rst) begin
            m_phase = 0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) stg[i] = 0;
            stg_col    = 0;
            started    = 1'b1;
            prev_stall = 1'b0;
        end else if (started) begin
            nst[0] = line_x0_valid ? int'(line_point) : stg[0];
            nst[1] = line_y0_valid ? int'(line_point) : stg[1];
            nst[2] = line_x1_valid ? int'(line_point) : stg[2];
            nst[3] = line_y1_valid ? int'(line_point) : stg[3];
            ncol   = line_color_valid ? int'(line_color[23:0]) : stg_col;
            case (m_phase)
                0: if (line_trigger) begin
                    build_line(nst[0], nst[1], nst[2], nst[3], ncol);
                    exp_q   = line_q;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (have && (px_ready || clp)) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_phase = 0;
                end
            endcase
            for (int i = 0; i < 4; i++) stg[i] = nst[i];
            stg_col    = ncol;
            prev_stall = px_valid && !px_ready;
            prev_x     = px_x;
            prev_y     = px_y;
            prev_c     = px_color;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic clear_strobes();
        line_x0_valid = 1'b0; line_y0_valid = 1'b0;
        line_x1_valid = 1'b0; line_y1_valid = 1'b0;
        line_color_valid = 1'b0; line_trigger = 1'b0;
    endtask

    task automatic start_line(int ax0, int ay0, int ax1, int ay1, logic [31:0] col, output int t);
        line_point = CW'(ax0); line_x0_valid = 1'b1;
        line_color = col; line_color_valid = 1'b1;
        tick(); clear_strobes();
        line_point = CW'(ay0); line_y0_valid = 1'b1;
        tick(); clear_strobes();
        line_point = CW'(ax1); line_x1_valid = 1'b1;
        tick(); clear_strobes();
        line_point = CW'(ay1); line_y1_valid = 1'b1; line_trigger = 1'b1;
        t = cyc;
        tick(); clear_strobes();
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (line_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(line_ready), 32'd1);
    endtask

    function automatic int clampc(int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c0, n, ax0, ay0, ax1, ay1;

        // Model pins
        build_line(0, 0, 1, 3, 0);
        pin("pin_steep", 4, '{0, 0, 1, 1, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0});
        build_line(3, 2, 0, 2, 0);
        pin("pin_rev", 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{2, 2, 2, 2, 0, 0, 0, 0});
        build_line(0, 0, 5, 2, 0);
        pin("pin_diag", 6, '{0, 1, 2, 3, 4, 5, 0, 0}, '{0, 0, 1, 1, 2, 2, 0, 0});
        build_line(5, 5, 5, 5, 0);
        pin("pin_degen", 1, '{5, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0});

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_px_x", 32'(px_x), 32'd0);
        check("rst_px_y", 32'(px_y), 32'd0);
        check("rst_px_color", 32'(px_color), 32'd0);
        check("rst_line_ready", 32'(line_ready), 32'd1);
        check("rst_px_valid", 32'(px_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Horizontal line, multi-strobe staging, write-through trigger, latency
        line_point = '0;
        line_x0_valid = 1'b1; line_y0_valid = 1'b1; line_y1_valid = 1'b1;
        line_color = 32'hAB00FF00; line_color_valid = 1'b1;
        tick(); clear_strobes();
        line_point = CW'(3); line_x1_valid = 1'b1; line_trigger = 1'b1;
        t = cyc; c0 = xfers;
        tick(); clear_strobes();
        at_cycle(t + 1);
        check("hz_setup_valid", 32'(px_valid), 32'd0);
        at_cycle(t + 2);
        check("hz_first_valid", 32'(px_valid), 32'd1);
        check("hz_first_x", 32'(px_x), 32'd0);
        check("hz_first_color", 32'(px_color), 32'h00FF00);
        at_cycle(t + 5);
        check("hz_busy", 32'(line_ready), 32'd0);
        at_cycle(t + 6);
        check("hz_ready_t6", 32'(line_ready), 32'd1);
        check("hz_count", xfers - c0, 32'd4);
        tick();

        // Steep, reversed, degenerate
        c0 = xfers; start_line(0, 0, 1, 3, 32'h123456, t); wait_idle(50);
        check("steep_count", xfers - c0, 32'd4);
        c0 = xfers; start_line(3, 2, 0, 2, 32'h654321, t); wait_idle(50);
        check("rev_count", xfers - c0, 32'd4);
        c0 = xfers; start_line(5, 5, 5, 5, 32'h0000AA, t); wait_idle(50);
        check("degen_count", xfers - c0, 32'd1);

        // Backpressure on second pixel, busy trigger, staged x1 for next line
        c0 = xfers;
        start_line(0, 0, 3, 0, 32'h00C0DE, t);
        tick();
        tick();
        px_ready = 1'b0; line_trigger = 1'b1;
        line_x1_valid = 1'b1; line_point = CW'(5);
        tick(); clear_strobes();
        tick();
        tick();
        px_ready = 1'b1;
        wait_idle(50);
        check("bp_count", xfers - c0, 32'd4);
        c0 = xfers;
        line_trigger = 1'b1;
        tick(); clear_strobes();
        wait_idle(50);
        check("restaged_count", xfers - c0, 32'd6);

        // Reset mid-draw
        start_line(0, 0, 3, 0, 32'h00FF00, t);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(px_valid), 32'd0);
        check("abort_ready", 32'(line_ready), 32'd1);
        c0 = xfers;
        repeat (6) tick();
        check("abort_no_more", xfers - c0, 32'd0);

`ifdef LINE_CLIP_EN
        c0 = xfers;
        start_line(798, 5, 801, 5, 32'h0000FF, t);
        at_cycle(t + 5);
        check("clip_busy", 32'(line_ready), 32'd0);
        at_cycle(t + 6);
        check("clip_ready_t6", 32'(line_ready), 32'd1);
        check("clip_count", xfers - c0, 32'd2);
        tick();
`endif

        // Random lines with random backpressure and ignored busy activity
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                ax0 = $urandom_range(0, 1023); ay0 = $urandom_range(0, 1023);
                ax1 = $urandom_range(0, 1023); ay1 = $urandom_range(0, 1023);
            end else begin
                ax0 = $urandom_range(0, 1023); ay0 = $urandom_range(0, 1023);
                ax1 = clampc(ax0 + int'($urandom_range(0, 96)) - 48);
                ay1 = clampc(ay0 + int'($urandom_range(0, 96)) - 48);
            end
            start_line(ax0, ay0, ax1, ay1, $urandom, t);
            n = 0;
            while (line_ready !== 1'b1 && n < 5000) begin
                px_ready      = ($urandom_range(0, 3) != 0);
                line_trigger  = ($urandom_range(0, 7) == 0);
                line_y0_valid = ($urandom_range(0, 7) == 0);
                line_point    = CW'($urandom_range(0, 1023));
                tick();
                n++;
            end
            clear_strobes();
            px_ready = 1'b1;
            check("rand_timeout", 32'(line_ready), 32'd1);
            tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
